motoro3_pwm_len_seq: RTL
========================

Name: motoro3_pwm_len_seq

Overview:
- Parametrised, multi-channel, sequential successor to the combinational PWM on-length calculator in the motor-3 control path.
- On a start pulse it snapshots its inputs, then uses one shared multiplier to compute one channel per cycle: power scaling, min/max clamp, and per-channel slew limiting.
- It also produces the saturated step length (lcStep + slLen) and signals completion with a one-cycle done pulse.
- Sits between the m3r register bank and the PWM generators.

Parameters:
- CH, 3, number of PWM channels (phases); 1..8
- PCT_W, 8, power-percent width; scale is pct/2^PCT_W
- LEN_W, 12, PWM length width (want, masks, slew, outputs)
- STEP_W, 4, lcStep width
- SLEN_W, 16, slLen / plLen width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request calculation; accepted only when busy=0
- m3r_power_percent  in  CH*PCT_W  per-channel power; channel k at [k*PCT_W +: PCT_W]
- m3r_pwmLenWant  in  LEN_W  full-scale PWM length
- m3r_pwmMinMask  in  LEN_W  lower clamp
- m3r_pwmMaxMask  in  LEN_W  upper clamp
- m3r_pwmSlewMax  in  LEN_W  max per-update change; 0 disables slew limiting
- lcStep  in  STEP_W  step offset
- slLen  in  SLEN_W  base step length
- busy  out  1  calculation in progress
- done  out  1  one-cycle pulse when all outputs are updated
- pwmLen  out  CH*LEN_W  registered per-channel PWM length
- plLen  out  SLEN_W  registered saturated lcStep + slLen
- plLen_sat  out  1  last plLen saturated
- clip_flags  out  CH  per channel: last result was min-clamped, max-clamped or slew-limited

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM to IDLE; busy=0, done=0, pwmLen=0, plLen=0, plLen_sat=0, clip_flags=0, channel index=0, snapshot registers=0.
- rst has priority over all other events, including a calculation in progress. A reset mid-calculation abandons it: no done pulse, outputs zero.
- FSM states:
  - IDLE: if start=1, snapshot all data inputs, set index=0, go to CALC, busy=1 from the next cycle.
  - CALC: one channel per cycle using the snapshot values; when index=CH-1, go to FIN.
  - FIN: write plLen/plLen_sat, pulse done=1, clear busy, return to IDLE.
- start is ignored while busy=1. start in the same cycle as the FIN cycle is also ignored (busy is still 1).
- Latency: start accepted at edge T → channel k written at edge T+1+k → plLen and done at edge T+CH+1. A new start is accepted at the earliest at edge T+CH+2.
- Per-channel arithmetic (channel k, all unsigned):
  - prod = pct_k * want, width PCT_W+LEN_W.
  - pos = prod >> PCT_W, truncated to LEN_W (cannot overflow).
  - c1 = (pos < min) ? min : pos.
  - tgt = (c1 > max) ? max : c1. If min > max, max wins.
  - prev = current pwmLen[k].
    - slew=0 or |tgt-prev| <= slew: new = tgt.
    - tgt > prev + slew: new = prev + slew.
    - tgt < prev - slew: new = prev - slew.
    - Compute the difference at LEN_W+1 bits so no wrap occurs.
  - clip_flags[k] = min-clamp OR max-clamp OR slew-limit, updated in the same cycle as pwmLen[k].
- plLen:
  - sum = lcStep + slLen at SLEN_W+1 bits.
  - If the carry bit is set: plLen = all ones, plLen_sat=1.
  - Otherwise: plLen = sum[SLEN_W-1:0], plLen_sat=0.
- Input changes during busy do not affect the calculation in progress (snapshot only).
- pwmLen channels not yet reached keep their previous values until written; downstream samples pwmLen only on done.

Decomposition:
- Package motoro3_pkg holds:
  - default widths: PCT_W_D=8, LEN_W_D=12, STEP_W_D=4, SLEN_W_D=16;
  - FSM state enum {IDLE, CALC, FIN};
  - function sat_add for the saturating add.
- One natural sub-module: motoro3_pwm_len_chan.
  - Combinational: scale, clamp and slew for one channel, with outputs new and clip.
  - The top instantiates it once and muxes its inputs by channel index.

Test Plan:
- Reset, then CH=3, pct={64,128,255}, want=2000, min=0, max=4095, slew=0, start → pwmLen={500,1000,1992}, done exactly 4 cycles after the start edge, clip_flags=0.
- pct=128, want=2000, min=1200 → pwmLen=1200, clip=1. Then min=0, max=800 → 800, clip=1. Then min=900, max=800 → 800 (max wins).
- slew=100, prev=0, target 1000: successive starts → 100, 200, 300, clip=1. Target 150 from prev 300 → 200. From prev 200, target 150 → 150, clip=0.
- lcStep=3, slLen=65534 → plLen=65535, plLen_sat=1. lcStep=5, slLen=1000 → plLen=1005, plLen_sat=0.
- start held high continuously; pct inputs changed mid-busy → one done per CH+2 cycles; results use the snapshot values only.
- rst asserted at cycle 2 of CALC → no done pulse, all outputs 0, busy=0 on the next cycle. A start after rst deasserts computes normally.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared widths, FSM state type and saturating-add helper for the motor-3
// PWM length sequencer.
package motoro3_pkg;

  localparam int PCT_W_D  = 8;
  localparam int LEN_W_D  = 12;
  localparam int STEP_W_D = 4;
  localparam int SLEN_W_D = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Unsigned add of two operands that saturates at w bits (w <= 32).
  // Result: bit 32 = saturated, bits [31:0] = clipped sum (upper bits zero).
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return {1'b1, lim[31:0]};
    end
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/motoro3_pwm_len_chan.sv
// One channel of the PWM on-length datapath: power scaling, min/max clamp
// and slew limiting against the channel's previous output. Purely
// combinational; the sequencer time-shares one instance over all channels.
module motoro3_pwm_len_chan
  import motoro3_pkg::*;
#(
  parameter int PCT_W = PCT_W_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic [PCT_W-1:0] pct_i,
  input  logic [LEN_W-1:0] want_i,
  input  logic [LEN_W-1:0] min_i,
  input  logic [LEN_W-1:0] max_i,
  input  logic [LEN_W-1:0] slew_i,
  input  logic [LEN_W-1:0] prev_i,
  output logic [LEN_W-1:0] new_o,
  output logic             clip_o
);

  logic [PCT_W+LEN_W-1:0] prod;
  logic [LEN_W-1:0]       pos;
  logic [LEN_W-1:0]       c1;
  logic [LEN_W-1:0]       tgt;
  logic                   min_hit;
  logic                   max_hit;
  logic                   slew_hit;
  logic [LEN_W:0]         up_diff;
  logic [LEN_W:0]         dn_diff;

  // Scale, clamp (max wins over min), then limit the step from prev.
  always_comb begin
    prod     = {{LEN_W{1'b0}}, pct_i} * {{PCT_W{1'b0}}, want_i};
    pos      = LEN_W'(prod >> PCT_W);
    min_hit  = (pos < min_i);
    c1       = min_hit ? min_i : pos;
    max_hit  = (c1 > max_i);
    tgt      = max_hit ? max_i : c1;
    up_diff  = {1'b0, tgt} - {1'b0, prev_i};
    dn_diff  = {1'b0, prev_i} - {1'b0, tgt};
    new_o    = tgt;
    slew_hit = 1'b0;
    if (slew_i != '0) begin
      if ((tgt > prev_i) && (up_diff > {1'b0, slew_i})) begin
        // prev + slew < tgt here, so the sum cannot wrap
        new_o    = prev_i + slew_i;
        slew_hit = 1'b1;
      end else if ((prev_i > tgt) && (dn_diff > {1'b0, slew_i})) begin
        new_o    = prev_i - slew_i;
        slew_hit = 1'b1;
      end
    end
    clip_o = min_hit | max_hit | slew_hit;
  end

endmodule

// File: rtl/motoro3_pwm_len_seq.sv
// Multi-channel sequential PWM on-length calculator. A start pulse snapshots
// the inputs; channels are then computed one per cycle through a single
// shared datapath, followed by the saturated step length and a done pulse.
module motoro3_pwm_len_seq
  import motoro3_pkg::*;
#(
  parameter int CH     = 3,
  parameter int PCT_W  = PCT_W_D,
  parameter int LEN_W  = LEN_W_D,
  parameter int STEP_W = STEP_W_D,
  parameter int SLEN_W = SLEN_W_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH*PCT_W-1:0]   m3r_power_percent,
  input  logic [LEN_W-1:0]      m3r_pwmLenWant,
  input  logic [LEN_W-1:0]      m3r_pwmMinMask,
  input  logic [LEN_W-1:0]      m3r_pwmMaxMask,
  input  logic [LEN_W-1:0]      m3r_pwmSlewMax,
  input  logic [STEP_W-1:0]     lcStep,
  input  logic [SLEN_W-1:0]     slLen,
  output logic                  busy,
  output logic                  done,
  output logic [CH*LEN_W-1:0]   pwmLen,
  output logic [SLEN_W-1:0]     plLen,
  output logic                  plLen_sat,
  output logic [CH-1:0]         clip_flags
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               snap_en;
  logic               chan_we;
  logic               fin_we;

  logic [CH*PCT_W-1:0] pct_q;
  logic [LEN_W-1:0]    want_q, min_q, max_q, slew_q;
  logic [STEP_W-1:0]   step_q;
  logic [SLEN_W-1:0]   sllen_q;

  logic [CH*LEN_W-1:0] len_all;
  logic [PCT_W-1:0]    pct_sel;
  logic [LEN_W-1:0]    prev_sel;
  logic [LEN_W-1:0]    chan_new;
  logic                chan_clip;

  logic [SLEN_W-1:0]   pl_len_q;
  logic                pl_sat_q;
  logic [32:0]         pl_res;

  // Next-state and strobes: IDLE accepts start, CALC walks the channels,
  // FIN publishes plLen and pulses done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    snap_en = 1'b0;
    chan_we = 1'b0;
    fin_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        chan_we = 1'b1;
        if (idx_q == IDX_W'(CH - 1)) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FIN: begin
        fin_we  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, channel index and done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Input snapshot taken when a start is accepted; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      pct_q   <= '0;
      want_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      slew_q  <= '0;
      step_q  <= '0;
      sllen_q <= '0;
    end else if (snap_en) begin
      pct_q   <= m3r_power_percent;
      want_q  <= m3r_pwmLenWant;
      min_q   <= m3r_pwmMinMask;
      max_q   <= m3r_pwmMaxMask;
      slew_q  <= m3r_pwmSlewMax;
      step_q  <= lcStep;
      sllen_q <= slLen;
    end
  end

  assign pct_sel  = pct_q[idx_q*PCT_W +: PCT_W];
  assign prev_sel = len_all[idx_q*LEN_W +: LEN_W];

  motoro3_pwm_len_chan #(
    .PCT_W (PCT_W),
    .LEN_W (LEN_W)
  ) u_chan (
    .pct_i  (pct_sel),
    .want_i (want_q),
    .min_i  (min_q),
    .max_i  (max_q),
    .slew_i (slew_q),
    .prev_i (prev_sel),
    .new_o  (chan_new),
    .clip_o (chan_clip)
  );

  // Per-channel result registers, written only in that channel's CALC slot.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [LEN_W-1:0] len_q;
    logic             clip_q;

    // Capture the shared datapath result when the index points here.
    always_ff @(posedge clk) begin
      if (rst) begin
        len_q  <= '0;
        clip_q <= 1'b0;
      end else if (chan_we && (idx_q == IDX_W'(gi))) begin
        len_q  <= chan_new;
        clip_q <= chan_clip;
      end
    end

    assign len_all[gi*LEN_W +: LEN_W] = len_q;
    assign clip_flags[gi]             = clip_q;
  end

  assign pl_res = sat_add(32'(step_q), 32'(sllen_q), SLEN_W);

  // Step length is published together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pl_len_q <= '0;
      pl_sat_q <= 1'b0;
    end else if (fin_we) begin
      pl_len_q <= SLEN_W'(pl_res);
      pl_sat_q <= pl_res[32];
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pwmLen    = len_all;
  assign plLen     = pl_len_q;
  assign plLen_sat = pl_sat_q;

endmodule
